// File: rtl/game_sequencer.sv
// Frame-paced game model for the dino OLED game: button conditioning, jump
// trajectory, obstacle scroll, score/speed ramp and collision detection.
module game_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned DINO_X          = 8,
  parameter int unsigned OBST_H          = 8,
  parameter int unsigned JUMP_V          = 7,
  parameter int unsigned SPEED_MAX       = 4,
  parameter int unsigned GO_LOCKOUT      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn1,
  input  logic [7:0] frame_number,
  output logic [1:0] game_state,
  output logic [6:0] obstacle_x,
  output logic [4:0] jump_height,
  output logic [9:0] score,
  output logic [2:0] speed,
  output logic       collision
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LOCK_W = (GO_LOCKOUT < 2) ? 1 : $clog2(GO_LOCKOUT + 1);
  localparam logic [6:0]  X_RELOAD  = 7'd127;
  localparam logic [9:0]  SCORE_MAX = 10'd999;
  localparam logic [6:0]  DINO_LO   = 7'(DINO_X);
  localparam logic [6:0]  DINO_HI   = 7'(DINO_X + 7);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_e;

  logic              btn_meta_q, btn_sync_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              db_level_q, db_level_d;
  logic              db_level_prev_q;
  logic              press_q, press_d;
  logic [7:0]        frame_q;
  logic              tick_q, tick_d;

  state_e            state_q, state_d;
  logic [6:0]        obst_x_q, obst_x_d;
  logic [4:0]        height_q, height_d;
  logic [4:0]        vel_q, vel_d;
  logic [9:0]        score_q, score_d;
  logic [2:0]        speed_q, speed_d;
  logic              collision_q, collision_d;
  logic [LOCK_W-1:0] lockout_q, lockout_d;
  logic              jump_req_q, jump_req_d;

  logic              grounded_c;
  logic              req_c;
  logic              start_run_c;
  logic signed [6:0] h_sum_c;
  logic [9:0]        score_inc_c;

  // Debounce: count consecutive cycles the synced input disagrees with the level
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    if (btn_sync_q != db_level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_level_d = btn_sync_q;
        db_cnt_d   = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
    press_d = db_level_prev_q & ~db_level_q;
    tick_d  = (frame_number != frame_q);
  end

  // Game FSM and datapath
  always_comb begin
    state_d     = state_q;
    obst_x_d    = obst_x_q;
    height_d    = height_q;
    vel_d       = vel_q;
    score_d     = score_q;
    speed_d     = speed_q;
    collision_d = 1'b0;
    lockout_d   = lockout_q;
    jump_req_d  = jump_req_q;
    start_run_c = 1'b0;
    grounded_c  = (height_q == 5'd0);
    req_c       = jump_req_q | (press_q & grounded_c);
    h_sum_c     = $signed({2'b00, height_q}) + $signed({{2{vel_q[4]}}, vel_q});
    score_inc_c = (score_q == SCORE_MAX) ? score_q : score_q + 10'd1;

    case (state_q)
      S_IDLE: begin
        if (press_q) start_run_c = 1'b1;
      end
      S_RUN: begin
        jump_req_d = req_c;
        if (tick_q) begin
          jump_req_d = 1'b0;
          if (grounded_c && req_c) begin
            vel_d    = 5'(JUMP_V - 1);
            height_d = 5'(JUMP_V);
          end else if (!grounded_c) begin
            if (h_sum_c <= 7'sd0) begin
              height_d = 5'd0;
              vel_d    = 5'd0;
            end else begin
              height_d = 5'(h_sum_c);
              vel_d    = vel_q - 5'd1;
            end
          end
          if (obst_x_q < 7'(speed_q)) begin
            obst_x_d = X_RELOAD;
            score_d  = score_inc_c;
            if ((score_inc_c[2:0] == 3'd0) && (score_inc_c != 10'd0) &&
                (speed_q < 3'(SPEED_MAX)))
              speed_d = speed_q + 3'd1;
          end else begin
            obst_x_d = obst_x_q - 7'(speed_q);
          end
          // Collision is judged on the positions just computed for this frame
          if ((obst_x_d >= DINO_LO) && (obst_x_d <= DINO_HI) &&
              ({1'b0, height_d} < 6'(OBST_H))) begin
            state_d     = S_OVER;
            collision_d = 1'b1;
            lockout_d   = LOCK_W'(GO_LOCKOUT);
            jump_req_d  = 1'b0;
          end
        end
      end
      S_OVER: begin
        if (tick_q && (lockout_q != '0)) lockout_d = lockout_q - LOCK_W'(1);
        if (press_q && (lockout_q == '0)) start_run_c = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (start_run_c) begin
      state_d    = S_RUN;
      obst_x_d   = X_RELOAD;
      height_d   = 5'd0;
      vel_d      = 5'd0;
      score_d    = 10'd0;
      speed_d    = 3'd1;
      jump_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_meta_q      <= 1'b1;
      btn_sync_q      <= 1'b1;
      db_cnt_q        <= '0;
      db_level_q      <= 1'b1;
      db_level_prev_q <= 1'b1;
      press_q         <= 1'b0;
      frame_q         <= 8'd0;
      tick_q          <= 1'b0;
      state_q         <= S_IDLE;
      obst_x_q        <= X_RELOAD;
      height_q        <= 5'd0;
      vel_q           <= 5'd0;
      score_q         <= 10'd0;
      speed_q         <= 3'd1;
      collision_q     <= 1'b0;
      lockout_q       <= '0;
      jump_req_q      <= 1'b0;
    end else begin
      btn_meta_q      <= btn1;
      btn_sync_q      <= btn_meta_q;
      db_cnt_q        <= db_cnt_d;
      db_level_q      <= db_level_d;
      db_level_prev_q <= db_level_q;
      press_q         <= press_d;
      frame_q         <= frame_number;
      tick_q          <= tick_d;
      state_q         <= state_d;
      obst_x_q        <= obst_x_d;
      height_q        <= height_d;
      vel_q           <= vel_d;
      score_q         <= score_d;
      speed_q         <= speed_d;
      collision_q     <= collision_d;
      lockout_q       <= lockout_d;
      jump_req_q      <= jump_req_d;
    end
  end

  assign game_state  = state_q;
  assign obstacle_x  = obst_x_q;
  assign jump_height = height_q;
  assign score       = score_q;
  assign speed       = speed_q;
  assign collision   = collision_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed + randomized bench for game_sequencer against a frame-level game model.
module tb_game_sequencer;

  localparam int JV = 7, SMAX = 4, LOCK = 32, DX = 8, OH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn1 = 1'b1;
  logic [7:0] frame_number = 8'd0;
  logic [1:0] game_state;
  logic [6:0] obstacle_x;
  logic [4:0] jump_height;
  logic [9:0] score;
  logic [2:0] speed;
  logic       collision;

  int total = 0;
  int bad   = 0;

  // Reference model: jump height from closed-form trajectory k*V - k(k-1)/2
  int m_state, m_x, m_h, m_k, m_score, m_speed, m_lock, m_coll;
  bit m_req;

  always #5 clk = ~clk;

  game_sequencer #(
    .DEBOUNCE_CYCLES(4), .DINO_X(8), .OBST_H(8), .JUMP_V(7), .SPEED_MAX(4), .GO_LOCKOUT(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn1(btn1), .frame_number(frame_number),
    .game_state(game_state), .obstacle_x(obstacle_x), .jump_height(jump_height),
    .score(score), .speed(speed), .collision(collision)
  );

  function automatic void m_reset();
    m_state = 0; m_x = 127; m_h = 0; m_k = 0; m_score = 0; m_speed = 1;
    m_lock = 0; m_coll = 0; m_req = 0;
  endfunction

  function automatic void m_start();
    m_state = 1; m_x = 127; m_h = 0; m_k = 0; m_score = 0; m_speed = 1; m_req = 0;
  endfunction

  function automatic void m_press();
    if (m_state == 0) m_start();
    else if (m_state == 2 && m_lock == 0) m_start();
    else if (m_state == 1 && m_k == 0) m_req = 1;
  endfunction

  function automatic void m_tick();
    m_coll = 0;
    if (m_state == 1) begin
      if (m_k == 0) begin
        if (m_req) m_k = 1;
      end else begin
        m_k++;
      end
      if (m_k > 0) begin
        m_h = m_k * JV - (m_k * (m_k - 1)) / 2;
        if (m_h <= 0) begin m_h = 0; m_k = 0; end
      end
      m_req = 0;
      if (m_x < m_speed) begin
        m_x = 127;
        if (m_score < 999) m_score++;
        if (m_score % 8 == 0) m_speed = (m_speed < SMAX) ? m_speed + 1 : SMAX;
      end else begin
        m_x = m_x - m_speed;
      end
      if (m_x >= DX && m_x <= DX + 7 && m_h < OH) begin
        m_state = 2; m_coll = 1; m_lock = LOCK;
      end
    end else if (m_state == 2 && m_lock > 0) begin
      m_lock--;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_state"},  32'(game_state),  32'(m_state));
    check({tag, "_x"},      32'(obstacle_x),  32'(m_x));
    check({tag, "_height"}, 32'(jump_height), 32'(m_h));
    check({tag, "_score"},  32'(score),       32'(m_score));
    check({tag, "_speed"},  32'(speed),       32'(m_speed));
  endtask

  task automatic tick(input string tag);
    @(posedge clk); #1 frame_number = frame_number + 8'($urandom_range(1, 255));
    m_tick();
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_all(tag);
    check({tag, "_coll"}, 32'(collision), 32'(m_coll));
    @(negedge clk);
    check({tag, "_coll_clr"}, 32'(collision), 32'd0);
  endtask

  task automatic press_btn(input string tag);
    @(posedge clk); #1 btn1 = 1'b0;
    repeat (12) @(posedge clk);
    #1 btn1 = 1'b1;
    repeat (12) @(posedge clk);
    m_press();
    @(negedge clk);
    check_all(tag);
  endtask

  // Press pulse and frame tick aligned to land in the same cycle
  task automatic press_and_tick(input string tag);
    @(posedge clk); #1 btn1 = 1'b0;
    repeat (6) @(posedge clk);
    #1 frame_number = frame_number + 8'd1;
    repeat (6) @(posedge clk);
    #1 btn1 = 1'b1;
    repeat (12) @(posedge clk);
    m_press();
    m_tick();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    m_reset();
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all("reset");
    check("reset_coll", 32'(collision), 32'd0);

    tick("idle_tick");
    press_btn("start");
    repeat (10) tick("scroll");
    check("scroll_x117", 32'(obstacle_x), 32'd117);

    press_btn("jump_press");
    for (int i = 1; i <= 15; i++) begin
      tick("jump");
      if (i == 3) press_btn("air_press");
    end
    check("jump_landed", 32'(jump_height), 32'd0);

    for (int i = 0; i < 3000 && m_score < 8; i++) begin
      if (m_k == 0 && m_x >= 16 + m_speed && m_x < 16 + 2 * m_speed)
        press_btn("auto_jump");
      else if (m_k != 0 && $urandom_range(0, 7) == 0)
        press_btn("air_press_rnd");
      prev = m_score;
      tick("run");
      if (prev == 7 && m_score == 8) begin
        check("ramp_speed", 32'(speed), 32'd2);
        check("ramp_x", 32'(obstacle_x), 32'd127);
      end
    end
    check("score8", 32'(score), 32'd8);

    for (int i = 0; i < 200 && m_state == 1; i++) tick("approach");
    check("game_over", 32'(game_state), 32'd2);
    repeat (3) tick("frozen");

    repeat (2) tick("lockout");
    press_btn("lockout_press");
    check("lockout_ignored", 32'(game_state), 32'd2);
    repeat (27) tick("lockout");
    press_btn("restart");
    check("restart_state", 32'(game_state), 32'd1);
    check("restart_score", 32'(score), 32'd0);

    press_and_tick("press_tick");
    check("press_tick_h7", 32'(jump_height), 32'd7);
    repeat (3) tick("pre_reset");

    @(posedge clk); #1 rst_n = 1'b0;
    repeat (4) @(posedge clk);
    m_reset();
    @(negedge clk);
    check_all("midrun_reset");
    #1 rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
